rle_stream_ctrl: RTL
====================

Name: rle_stream_ctrl

Overview:
- Sequences one run-length-encoding job through the existing path: input FIFO (8-bit) → rle_enc → output FIFO (24-bit).
- Replaces the raw write-request, flush and reset handshakes the HPS currently drives through PIOs with a hardware job sequencer.
- Software supplies a byte count and a start pulse. The controller then:
  - clears the encoder and both FIFOs;
  - streams source bytes into the input FIFO under backpressure;
  - waits for the input FIFO to drain;
  - flushes the encoder and reports completion.

Parameters:
- LEN_W, 16, width of job length and all counters.
- CLR_CYCLES, 4, cycles enc_rst is held high at job start (≥2, satisfies FIFO aclr).
- FLUSH_TIMEOUT, 1024, maximum cycles in FLUSH waiting for the final record.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle job start pulse.
- abort  in  1  one-cycle job abort pulse.
- job_len  in  LEN_W  number of bytes in the job; sampled on an accepted start.
- src_data  in  8  source byte.
- src_valid  in  1  src_data valid.
- src_ready  out  1  controller accepts src_data this cycle.
- fifo_in_wdata  out  8  to input FIFO data.
- fifo_in_wrreq  out  1  to input FIFO wrreq.
- fifo_in_full  in  1  input FIFO wrfull.
- fifo_in_empty  in  1  input FIFO rdempty.
- enc_wr_req  in  1  rle_enc wr_req (record emitted to output FIFO).
- enc_rst  out  1  to rle_enc rst and aclr of both FIFOs.
- enc_flush  out  1  to rle_enc end_of_stream.
- busy  out  1  job in progress (any state except IDLE and DONE).
- done  out  1  job finished; held until the next start or abort.
- timeout_err  out  1  last job ended by flush timeout.
- bytes_sent  out  LEN_W  bytes written to the input FIFO in the current or last job.
- records_out  out  LEN_W  enc_wr_req pulses seen in the current or last job; saturates at all-ones.

Behaviour:

Reset:
- State goes to IDLE.
- All outputs are 0, including enc_rst, enc_flush, done, timeout_err and both counters.

States:
- IDLE. On start: latch job_len, clear bytes_sent, records_out and timeout_err, go to CLR.
- CLR. enc_rst=1 for exactly CLR_CYCLES cycles, then go to FEED. If the latched length is 0, go directly to DONE instead; no flush is issued.
- FEED.
  - src_ready = !fifo_in_full && (bytes_sent < len).
  - A transfer occurs when src_valid && src_ready. In that same cycle (combinational, zero latency): fifo_in_wrreq=1, fifo_in_wdata=src_data, and bytes_sent increments at the clock edge.
  - When bytes_sent reaches len, go to DRAIN. src_ready is 0 from that cycle on.
- DRAIN. Wait for fifo_in_empty=1, then go to FLUSH.
- FLUSH.
  - enc_flush=1.
  - On the first enc_wr_req seen in FLUSH, go to DONE.
  - If FLUSH_TIMEOUT cycles elapse with no enc_wr_req, go to DONE with timeout_err=1.
- DONE. done=1, enc_flush=0.
  - On start: begin a new job exactly as from IDLE (done clears).
  - On abort: go to IDLE (done clears).

Flow rules:
- fifo_in_wrreq is never asserted while fifo_in_full=1 or outside FEED.
- records_out increments on every enc_wr_req seen in CLR, FEED, DRAIN or FLUSH.

Abort:
- Abort in CLR, FEED, DRAIN or FLUSH goes to CLR (a full CLR_CYCLES clear), then to IDLE rather than FEED.
- done stays 0; counters hold their values at the abort.

Simultaneous and boundary events:
- start and abort in the same cycle: abort wins.
- start while busy is ignored.
- abort in IDLE is ignored.
- enc_wr_req in the same cycle as the timeout expires counts as success; timeout_err stays 0.
- rst mid-job immediately returns the block to IDLE with all outputs 0. The FIFOs are not cleared until the next start.

Test Plan:
- job_len=5, bytes 0x41,0x41,0x41,0x42,0x42 with src_valid held high, FIFO never full → enc_rst high exactly 4 cycles; 5 consecutive wrreq pulses; DRAIN, then FLUSH; first enc_wr_req gives done=1, bytes_sent=5, records_out=2.
- job_len=8, fifo_in_full forced high for 3 cycles mid-stream → src_ready and fifo_in_wrreq low in those cycles; no byte lost or duplicated; bytes_sent=8.
- job_len=0 → CLR for 4 cycles then DONE; enc_flush never asserted; bytes_sent=0.
- Abort after 3 of 10 bytes → enc_rst high 4 cycles; state IDLE; done=0; bytes_sent=3; a following start with job_len=2 completes normally.
- FLUSH with no enc_wr_req (FLUSH_TIMEOUT=16) → DONE after 16 cycles with timeout_err=1, done=1.
- start asserted while in FEED, and start+abort in the same cycle → the start is ignored; the combined pulse aborts; rst asserted mid-FEED drives all outputs to 0 asynchronously.

Source files
------------

// File: rtl/rle_stream_ctrl_if.sv
// Handshake bundle between the run-length-encoding job sequencer and its surroundings
// (software control, byte source, input FIFO and rle_enc).
interface rle_stream_ctrl_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] job_len;
    logic [7:0]       src_data;
    logic             src_valid;
    logic             src_ready;
    logic [7:0]       fifo_in_wdata;
    logic             fifo_in_wrreq;
    logic             fifo_in_full;
    logic             fifo_in_empty;
    logic             enc_wr_req;
    logic             enc_rst;
    logic             enc_flush;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [LEN_W-1:0] bytes_sent;
    logic [LEN_W-1:0] records_out;

    modport master (
        output start, abort, job_len, src_data, src_valid,
               fifo_in_full, fifo_in_empty, enc_wr_req,
        input  src_ready, fifo_in_wdata, fifo_in_wrreq, enc_rst, enc_flush,
               busy, done, timeout_err, bytes_sent, records_out
    );

    modport slave (
        input  start, abort, job_len, src_data, src_valid,
               fifo_in_full, fifo_in_empty, enc_wr_req,
        output src_ready, fifo_in_wdata, fifo_in_wrreq, enc_rst, enc_flush,
               busy, done, timeout_err, bytes_sent, records_out
    );
endinterface

// File: rtl/rle_stream_ctrl.sv
// Hardware job sequencer for one RLE job: clear encoder and FIFOs, stream the source
// bytes into the input FIFO, wait for it to drain, then flush the encoder.
module rle_stream_ctrl #(
    parameter int LEN_W         = 16,
    parameter int CLR_CYCLES    = 4,
    parameter int FLUSH_TIMEOUT = 1024
) (
    input logic              clk,
    input logic              rst,
    rle_stream_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, FLUSH, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] clr_cnt;
    logic [LEN_W-1:0] flush_cnt;
    logic [LEN_W-1:0] bytes_sent;
    logic [LEN_W-1:0] records_out;
    logic             aborting;
    logic             timeout_err;
    logic             enc_rst;
    logic             enc_flush;
    logic             busy;
    logic             done;
    logic             in_job;
    logic             abort_hit;
    logic             start_job;
    logic             src_ready;
    logic             xfer;
    logic             clr_last;
    logic             flush_last;

    assign src_ready = (state == FEED) && !bus.fifo_in_full && (bytes_sent < len);
    assign xfer      = src_ready && bus.src_valid;

    always_comb begin
        in_job     = (state == CLR) || (state == FEED) || (state == DRAIN) || (state == FLUSH);
        abort_hit  = bus.abort && in_job;
        start_job  = bus.start && !bus.abort && ((state == IDLE) || (state == DONE));
        clr_last   = (clr_cnt == LEN_W'(CLR_CYCLES - 1));
        flush_last = (flush_cnt == LEN_W'(FLUSH_TIMEOUT - 1));
        state_nx   = state;
        if (abort_hit) begin
            state_nx = CLR;
        end else begin
            case (state)
                IDLE:  if (start_job) state_nx = CLR;
                CLR: begin
                    // An aborted job still gets a full clear but never resumes streaming.
                    if (clr_last) begin
                        if (aborting)          state_nx = IDLE;
                        else if (len == '0)    state_nx = DONE;
                        else                   state_nx = FEED;
                    end
                end
                FEED:  if (xfer && (bytes_sent + LEN_W'(1) == len)) state_nx = DRAIN;
                DRAIN: if (bus.fifo_in_empty) state_nx = FLUSH;
                FLUSH: if (bus.enc_wr_req || flush_last) state_nx = DONE;
                DONE: begin
                    if (bus.abort)      state_nx = IDLE;
                    else if (start_job) state_nx = CLR;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len         <= '0;
            clr_cnt     <= '0;
            flush_cnt   <= '0;
            bytes_sent  <= '0;
            records_out <= '0;
            aborting    <= 1'b0;
            timeout_err <= 1'b0;
            enc_rst     <= 1'b0;
            enc_flush   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state     <= state_nx;
            enc_rst   <= (state_nx == CLR);
            enc_flush <= (state_nx == FLUSH);
            busy      <= state_nx inside {CLR, FEED, DRAIN, FLUSH};
            done      <= (state_nx == DONE);

            // Re-entering CLR on an abort restarts the clear from zero.
            if ((state_nx != state) || abort_hit) begin
                clr_cnt   <= '0;
                flush_cnt <= '0;
            end else begin
                if (state == CLR)   clr_cnt   <= clr_cnt + LEN_W'(1);
                if (state == FLUSH) flush_cnt <= flush_cnt + LEN_W'(1);
            end

            if (abort_hit)              aborting <= 1'b1;
            else if (state_nx == IDLE)  aborting <= 1'b0;

            if (start_job) begin
                len         <= bus.job_len;
                bytes_sent  <= '0;
                records_out <= '0;
                timeout_err <= 1'b0;
            end else begin
                if (xfer) bytes_sent <= bytes_sent + LEN_W'(1);
                // Counters freeze once a job is aborted.
                if (bus.enc_wr_req && in_job && !aborting && (records_out != '1))
                    records_out <= records_out + LEN_W'(1);
                if ((state == FLUSH) && (state_nx == DONE) && !bus.enc_wr_req)
                    timeout_err <= 1'b1;
            end
        end
    end

    assign bus.src_ready     = src_ready;
    assign bus.fifo_in_wrreq = xfer;
    assign bus.fifo_in_wdata = xfer ? bus.src_data : 8'h00;
    assign bus.enc_rst       = enc_rst;
    assign bus.enc_flush     = enc_flush;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.timeout_err   = timeout_err;
    assign bus.bytes_sent    = bytes_sent;
    assign bus.records_out   = records_out;

endmodule
